// File: rtl/load_store_unit.sv
// Load/store unit: turns MemRead/MemWrite requests into single-beat data memory
// accesses with byte lanes, alignment and legality checks, load extension and an
// ack timeout. Stalls the pipeline while a request is pending.
module load_store_unit #(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DM_ADDRESS-1:0] a,
    input  logic [DATA_W-1:0]     wd,
    output logic [DATA_W-1:0]     rd,
    output logic                  stall,
    output logic                  done,
    output logic                  fault,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q;
    logic              load_q;
    logic [2:0]        f3_q;
    logic [1:0]        lane_q;

    logic              req_in;
    logic              legal;
    logic              misaligned;
    logic              req_ok;
    logic              tmo;
    logic [3:0]        be_d;
    logic [DATA_W-1:0] wdata_d;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] ld_data;

    assign req_in = MemRead | MemWrite;
    // Last waiting cycle: without ack this edge takes the counter to TIMEOUT.
    assign tmo    = (cnt_q == CntW'(TIMEOUT - 1));
    assign req_ok = legal & ~misaligned;

    // Decode legality, alignment, byte enables and lane-replicated store data.
    always_comb begin
        legal      = 1'b0;
        misaligned = 1'b0;
        be_d       = 4'b1111;
        wdata_d    = wd;
        if (MemRead) begin
            legal = Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end else begin
            legal = Funct3 inside {3'b000, 3'b001, 3'b010};
        end
        case (Funct3[1:0])
            2'b01:   misaligned = a[0];
            2'b10:   misaligned = (a[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        if (!MemRead) begin
            case (Funct3[1:0])
                2'b00: begin
                    be_d    = 4'b0001 << a[1:0];
                    wdata_d = {4{wd[7:0]}};
                end
                2'b01: begin
                    be_d    = a[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{wd[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = wd;
                end
            endcase
        end
    end

    // Select the addressed lane of the read word and extend it.
    always_comb begin
        byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_data = {{(DATA_W - 8){byte_sel[7]}}, byte_sel};
            3'b001:  ld_data = {{(DATA_W - 16){half_sel[15]}}, half_sel};
            3'b010:  ld_data = mem_rdata;
            3'b100:  ld_data = {{(DATA_W - 8){1'b0}}, byte_sel};
            3'b101:  ld_data = {{(DATA_W - 16){1'b0}}, half_sel};
            default: ld_data = '0;
        endcase
    end

    // Next-state logic and combinational stall.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            StIdle: begin
                stall = req_in;
                if (req_in) begin
                    state_d = req_ok ? StReq : StDone;
                end
            end
            StReq: begin
                stall = 1'b1;
                if (mem_ack || tmo) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register and wait counter (held at zero outside REQ).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q != StReq) begin
                cnt_q <= '0;
            end else if (!mem_ack) begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    // Capture access attributes needed at completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q <= 1'b0;
            f3_q   <= 3'b000;
            lane_q <= 2'b00;
        end else if (state_q == StIdle && req_in) begin
            load_q <= MemRead;
            f3_q   <= Funct3;
            lane_q <= a[1:0];
        end
    end

    // Registered memory interface, held stable for the whole REQ phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 4'b0000;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_in && req_ok) begin
                        mem_req   <= 1'b1;
                        mem_we    <= ~MemRead;
                        mem_addr  <= {a[DM_ADDRESS-1:2], 2'b00};
                        mem_wdata <= wdata_d;
                        mem_be    <= be_d;
                    end
                end
                StReq: begin
                    if (mem_ack || tmo) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Completion pulse plus result and fault, which hold until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done  <= 1'b0;
            fault <= 1'b0;
            rd    <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_in && !req_ok) begin
                        done  <= 1'b1;
                        fault <= 1'b1;
                        rd    <= '0;
                    end
                end
                StReq: begin
                    // Ack wins over a simultaneous timeout.
                    if (mem_ack) begin
                        done  <= 1'b1;
                        fault <= 1'b0;
                        rd    <= load_q ? ld_data : '0;
                    end else if (tmo) begin
                        done  <= 1'b1;
                        fault <= 1'b1;
                        rd    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        stall, done, fault;
    logic        mem_req, mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] Idle_rdata = 32'h5A5A_5A5A;

    always #5 clk = ~clk;

    load_store_unit #(.DM_ADDRESS(9), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .Funct3(Funct3), .a(a), .wd(wd), .rd(rd), .stall(stall), .done(done),
        .fault(fault), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // Drives one access starting at a negedge, acks on the ack_at-th mem_req cycle
    // (0 = never), and reports what it saw. Cycle 0 is the request cycle.
    task automatic run_access(input logic is_rd, input logic is_wr, input logic [2:0] f3,
                              input logic [8:0] addr, input logic [31:0] data,
                              input int ack_at, input logic [31:0] rdata,
                              output int n_req, output int n_stall, output int t_done,
                              output logic [8:0] o_addr, output logic [3:0] o_be,
                              output logic [31:0] o_wdata, output logic o_we);
        MemRead = is_rd; MemWrite = is_wr; Funct3 = f3; a = addr; wd = data;
        mem_ack = 1'b0; mem_rdata = Idle_rdata;
        n_req = 0; n_stall = 0; t_done = -1;
        o_addr = '0; o_be = '0; o_wdata = '0; o_we = 1'b0;
        for (int c = 0; c < 40 && t_done < 0; c++) begin
            #1;
            if (stall) n_stall++;
            if (mem_req) begin
                n_req++;
                if (n_req == 1) begin
                    o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata; o_we = mem_we;
                end
                if (n_req == ack_at) begin
                    mem_ack = 1'b1; mem_rdata = rdata;
                end
            end
            if (done) t_done = c;
            if (!stall) begin
                MemRead = 1'b0; MemWrite = 1'b0;
            end
            @(negedge clk);
            mem_ack = 1'b0; mem_rdata = Idle_rdata;
        end
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_rd: got %h want 0", rd); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", fault); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        n_checks++; if (mem_addr !== 9'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        n_checks++; if (mem_be !== 4'h0) begin n_fail++; $display("FAIL reset_mem_be: got %b want 0", mem_be); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_idle: got %b want 0", stall); end
        MemWrite = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_req: got %b want 1", stall); end
        MemWrite = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stores();
        int nr, ns, td; logic [8:0] ad; logic [3:0] be; logic [31:0] wdt; logic we;
        run_access(1'b0, 1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 1, 32'h0, nr, ns, td, ad, be, wdt, we);
        n_checks++; if (td !== 2) begin n_fail++; $display("FAIL sw_done_time: got %0d want 2", td); end
        n_checks++; if (nr !== 1) begin n_fail++; $display("FAIL sw_req_cycles: got %0d want 1", nr); end
        n_checks++; if (ad !== 9'h010) begin n_fail++; $display("FAIL sw_addr: got %h want 010", ad); end
        n_checks++; if (be !== 4'b1111) begin n_fail++; $display("FAIL sw_be: got %b want 1111", be); end
        n_checks++; if (wdt !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata: got %h want deadbeef", wdt); end
        n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL sw_we: got %b want 1", we); end
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL sw_fault: got %b want 0", fault); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL sw_rd: got %h want 0", rd); end

        run_access(1'b0, 1'b1, 3'b000, 9'h013, 32'h000000A5, 1, 32'h0, nr, ns, td, ad, be, wdt, we);
        n_checks++; if (be !== 4'b1000) begin n_fail++; $display("FAIL sb_be: got %b want 1000", be); end
        n_checks++; if (wdt !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h want a5a5a5a5", wdt); end
        n_checks++; if (ad !== 9'h010) begin n_fail++; $display("FAIL sb_addr: got %h want 010", ad); end

        run_access(1'b0, 1'b1, 3'b001, 9'h012, 32'h1234ABCD, 1, 32'h0, nr, ns, td, ad, be, wdt, we);
        n_checks++; if (be !== 4'b1100) begin n_fail++; $display("FAIL sh_be: got %b want 1100", be); end
        n_checks++; if (wdt !== 32'hABCDABCD) begin n_fail++; $display("FAIL sh_wdata: got %h want abcdabcd", wdt); end
        n_checks++; if (ad !== 9'h010) begin n_fail++; $display("FAIL sh_addr: got %h want 010", ad); end
    endtask

    task automatic test_loads();
        int nr, ns, td; logic [8:0] ad; logic [3:0] be; logic [31:0] wdt; logic we;
        run_access(1'b1, 1'b0, 3'b000, 9'h021, 32'h0, 3, 32'h0000F000, nr, ns, td, ad, be, wdt, we);
        n_checks++; if (rd !== 32'hFFFFFFF0) begin n_fail++; $display("FAIL lb_rd: got %h want fffffff0", rd); end
        n_checks++; if (ns !== 4) begin n_fail++; $display("FAIL lb_stall_cycles: got %0d want 4", ns); end
        n_checks++; if (td !== 4) begin n_fail++; $display("FAIL lb_done_time: got %0d want 4", td); end
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL lb_we: got %b want 0", we); end
        n_checks++; if (be !== 4'b1111) begin n_fail++; $display("FAIL lb_be: got %b want 1111", be); end
        n_checks++; if (ad !== 9'h020) begin n_fail++; $display("FAIL lb_addr: got %h want 020", ad); end
        @(negedge clk);
        n_checks++; if (rd !== 32'hFFFFFFF0) begin n_fail++; $display("FAIL lb_rd_hold: got %h want fffffff0", rd); end

        run_access(1'b1, 1'b0, 3'b100, 9'h021, 32'h0, 3, 32'h0000F000, nr, ns, td, ad, be, wdt, we);
        n_checks++; if (rd !== 32'h000000F0) begin n_fail++; $display("FAIL lbu_rd: got %h want 000000f0", rd); end

        run_access(1'b1, 1'b0, 3'b001, 9'h006, 32'h0, 1, 32'h80000000, nr, ns, td, ad, be, wdt, we);
        n_checks++; if (rd !== 32'hFFFF8000) begin n_fail++; $display("FAIL lh_rd: got %h want ffff8000", rd); end
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL lh_fault: got %b want 0", fault); end

        run_access(1'b1, 1'b0, 3'b101, 9'h004, 32'h0, 1, 32'h1234FEDC, nr, ns, td, ad, be, wdt, we);
        n_checks++; if (rd !== 32'h0000FEDC) begin n_fail++; $display("FAIL lhu_rd: got %h want 0000fedc", rd); end
    endtask

    task automatic test_faults();
        int nr, ns, td; logic [8:0] ad; logic [3:0] be; logic [31:0] wdt; logic we;
        run_access(1'b1, 1'b0, 3'b010, 9'h006, 32'h0, 1, 32'hFFFFFFFF, nr, ns, td, ad, be, wdt, we);
        n_checks++; if (nr !== 0) begin n_fail++; $display("FAIL lw_mis_req: got %0d want 0", nr); end
        n_checks++; if (td !== 1) begin n_fail++; $display("FAIL lw_mis_done_time: got %0d want 1", td); end
        n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL lw_mis_fault: got %b want 1", fault); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL lw_mis_rd: got %h want 0", rd); end

        run_access(1'b0, 1'b1, 3'b001, 9'h013, 32'h1, 1, 32'h0, nr, ns, td, ad, be, wdt, we);
        n_checks++; if (nr !== 0 || fault !== 1'b1) begin n_fail++; $display("FAIL sh_mis: got req=%0d fault=%b want 0/1", nr, fault); end

        run_access(1'b1, 1'b0, 3'b011, 9'h000, 32'h0, 1, 32'h1, nr, ns, td, ad, be, wdt, we);
        n_checks++; if (nr !== 0 || fault !== 1'b1) begin n_fail++; $display("FAIL ld_illegal: got req=%0d fault=%b want 0/1", nr, fault); end

        run_access(1'b0, 1'b1, 3'b100, 9'h000, 32'h0, 1, 32'h0, nr, ns, td, ad, be, wdt, we);
        n_checks++; if (nr !== 0 || fault !== 1'b1) begin n_fail++; $display("FAIL st_illegal: got req=%0d fault=%b want 0/1", nr, fault); end
    endtask

    task automatic test_timeout();
        int nr, ns, td; logic [8:0] ad; logic [3:0] be; logic [31:0] wdt; logic we;
        run_access(1'b1, 1'b0, 3'b010, 9'h040, 32'h0, 15, 32'hCAFEF00D, nr, ns, td, ad, be, wdt, we);
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL ack_at_timeout_fault: got %b want 0", fault); end
        n_checks++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL ack_at_timeout_rd: got %h want cafef00d", rd); end
        n_checks++; if (nr !== 15) begin n_fail++; $display("FAIL ack_at_timeout_req: got %0d want 15", nr); end

        run_access(1'b1, 1'b0, 3'b010, 9'h040, 32'h0, 0, 32'h0, nr, ns, td, ad, be, wdt, we);
        n_checks++; if (nr !== 15) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d want 15", nr); end
        n_checks++; if (td !== 16) begin n_fail++; $display("FAIL timeout_done_time: got %0d want 16", td); end
        n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL timeout_fault: got %b want 1", fault); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL timeout_rd: got %h want 0", rd); end
    endtask

    task automatic test_ack_ignored();
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL idle_ack: got done=%b req=%b want 0/0", done, mem_req); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL idle_ack_rd: got %h want 0", rd); end
        mem_ack = 1'b0; mem_rdata = Idle_rdata;
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int nr, ns, td, seen; logic [8:0] ad; logic [3:0] be; logic [31:0] wdt; logic we;
        MemRead = 1'b1; Funct3 = 3'b010; a = 9'h020;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL abort_req_start: got %b want 1", mem_req); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL abort_req_low: got %b want 0", mem_req); end
        n_checks++; if (mem_addr !== 9'h0 || mem_be !== 4'h0) begin n_fail++; $display("FAIL abort_bus_clear: got addr=%h be=%b want 0/0", mem_addr, mem_be); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL abort_stall: got %b want 1", stall); end
        MemRead = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
        run_access(1'b0, 1'b1, 3'b010, 9'h030, 32'h0BADF00D, 1, 32'h0, nr, ns, td, ad, be, wdt, we);
        n_checks++; if (td !== 2) begin n_fail++; $display("FAIL post_abort_done_time: got %0d want 2", td); end
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL post_abort_fault: got %b want 0", fault); end
        n_checks++; if (wdt !== 32'h0BADF00D || ad !== 9'h030) begin n_fail++; $display("FAIL post_abort_bus: got %h@%h want 0badf00d@030", wdt, ad); end
    endtask

    initial begin
        MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000; a = '0; wd = '0;
        mem_ack = 1'b0; mem_rdata = Idle_rdata;
        test_reset();
        test_stores();
        test_loads();
        test_faults();
        test_timeout();
        test_ack_ignored();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
